// File: rtl/one_wire_byte_sequencer.sv
// Byte-level command sequencer in front of a 1-Wire bit master: reset / write-byte / read-byte, LSB first.
// Optional Dallas/Maxim CRC-8 accumulator is built when ONE_WIRE_CRC8_EN is defined.
module one_wire_byte_sequencer #(
    parameter int DONE_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_presence,
    output logic       rsp_err,
    output logic       busy,
    output logic       m_start_reset,
    output logic       m_start_write_bit,
    output logic       m_start_read_bit,
    output logic       m_write_bit_data,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_read_bit_data,
    input  logic       m_presence_detected,
    input  logic       crc_clear,
    output logic [7:0] crc_value
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam int WD_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DONE_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rsp_presence_q, rsp_presence_d;
    logic            rsp_err_q, rsp_err_d;
    logic [7:0]      shreg_next;

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        shreg_d           = shreg_q;
        cnt_d             = cnt_q;
        wdog_d            = wdog_q;
        rsp_data_d        = rsp_data_q;
        rsp_presence_d    = rsp_presence_q;
        rsp_err_d         = rsp_err_q;
        m_start_reset     = 1'b0;
        m_start_write_bit = 1'b0;
        m_start_read_bit  = 1'b0;
        shreg_next        = (op_q == OP_READ) ? {m_read_bit_data, shreg_q[7:1]}
                                              : {1'b0, shreg_q[7:1]};

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    shreg_d = cmd_data;
                    cnt_d   = 4'd0;
                    wdog_d  = '0;
                    if (cmd_op == OP_RSVD) begin
                        rsp_data_d     = 8'h00;
                        rsp_presence_d = 1'b0;
                        rsp_err_d      = 1'b1;
                        state_d        = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!m_busy) begin
                    m_start_reset     = (op_q == OP_RESET);
                    m_start_write_bit = (op_q == OP_WRITE);
                    m_start_read_bit  = (op_q == OP_READ);
                    wdog_d            = '0;
                    state_d           = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_done) begin
                    // A bus reset is a single master op; a byte is eight.
                    shreg_d = shreg_next;
                    cnt_d   = cnt_q + 4'd1;
                    if (op_q == OP_RESET || cnt_q == 4'd7) begin
                        rsp_data_d     = (op_q == OP_READ) ? shreg_next : 8'h00;
                        rsp_presence_d = (op_q == OP_RESET) ? m_presence_detected : 1'b0;
                        rsp_err_d      = 1'b0;
                        state_d        = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (DONE_TIMEOUT != 0 && wdog_q == WD_LAST) begin
                    rsp_data_d     = 8'h00;
                    rsp_presence_d = 1'b0;
                    rsp_err_d      = 1'b1;
                    state_d        = S_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_q           <= OP_RESET;
            shreg_q        <= 8'h00;
            cnt_q          <= 4'd0;
            wdog_q         <= '0;
            rsp_data_q     <= 8'h00;
            rsp_presence_q <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            shreg_q        <= shreg_d;
            cnt_q          <= cnt_d;
            wdog_q         <= wdog_d;
            rsp_data_q     <= rsp_data_d;
            rsp_presence_q <= rsp_presence_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    assign cmd_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign rsp_valid        = (state_q == S_RESP);
    assign rsp_data         = rsp_data_q;
    assign rsp_presence     = rsp_presence_q;
    assign rsp_err          = rsp_err_q;
    // Write bit only shifts on m_done, so it stays stable across the strobe/wait window.
    assign m_write_bit_data = (op_q == OP_WRITE) && (state_q == S_ISSUE || state_q == S_WAIT)
                              && shreg_q[0];

`ifdef ONE_WIRE_CRC8_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_bit_en;
    logic       crc_bit;
    logic       crc_op_reset;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return fb ? ({1'b0, crc[7:1]} ^ 8'h8C) : {1'b0, crc[7:1]};
    endfunction

    assign crc_bit_en   = (state_q == S_WAIT) && m_done && (op_q != OP_RESET);
    assign crc_bit      = (op_q == OP_READ) ? m_read_bit_data : shreg_q[0];
    assign crc_op_reset = (state_q == S_IDLE) && cmd_valid && (cmd_op == OP_RESET);

    always_comb begin
        crc_d = crc_q;
        if (crc_clear || crc_op_reset) begin
            crc_d = 8'h00;
        end else if (crc_bit_en) begin
            crc_d = crc8_step(crc_q, crc_bit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_value = crc_q;
`else
    logic unused_crc_clear;
    assign unused_crc_clear = crc_clear;
    assign crc_value        = 8'h00;
`endif

endmodule

// File: tb/tb_one_wire_byte_sequencer.sv
// Randomized scoreboard bench for one_wire_byte_sequencer with a behavioural 1-Wire bit-master model.
// Exercises the CRC-8 path as well when ONE_WIRE_CRC8_EN is defined.
module tb_one_wire_byte_sequencer;

    localparam int TO = 16;
`ifdef ONE_WIRE_CRC8_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic       clk, rst;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_presence, rsp_err, busy;
    logic [7:0] rsp_data;
    logic       m_start_reset, m_start_write_bit, m_start_read_bit, m_write_bit_data;
    logic       m_busy, m_done, m_read_bit_data, m_presence_detected;
    logic       crc_clear;
    logic [7:0] crc_value;

    one_wire_byte_sequencer #(.DONE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_presence(rsp_presence), .rsp_err(rsp_err),
        .busy(busy),
        .m_start_reset(m_start_reset), .m_start_write_bit(m_start_write_bit),
        .m_start_read_bit(m_start_read_bit), .m_write_bit_data(m_write_bit_data),
        .m_busy(m_busy), .m_done(m_done), .m_read_bit_data(m_read_bit_data),
        .m_presence_detected(m_presence_detected),
        .crc_clear(crc_clear), .crc_value(crc_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       pres;
        logic       err;
        int         nrst;
        int         nwr;
        int         nrd;
        logic [7:0] wseq;
        logic [7:0] crc;
        int         acc_cyc;
        bit         chk_to;
        bit         chk_rsv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Master model configuration (driver-owned) and activity log (master-owned).
    bit         never_done = 1'b0;
    logic       pres_cfg = 1'b0;
    logic [7:0] rd_byte = 8'h00;
    int         rd_base = 0;
    logic [7:0] model_crc = 8'h00;
    int         tot_rst = 0, tot_wr = 0, tot_rd = 0, last_strobe_cyc = 0;
    logic       wbit_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 8'h8C;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Behavioural bit master: random latency, optional post-done busy, never overlaps strobes.
    initial begin
        bit   st_r, st_w, st_rd, pend, pend_w;
        int   cnt, rec, idx;
        logic pwbit;
        m_busy = 0; m_done = 0; m_read_bit_data = 0; m_presence_detected = 0;
        pend = 0; pend_w = 0; cnt = 0; rec = 0; pwbit = 0;
        forever begin
            @(negedge clk);
            st_r  = m_start_reset;
            st_w  = m_start_write_bit;
            st_rd = m_start_read_bit;
            if (!rst) begin
                if (st_r || st_w || st_rd) begin
                    check("strobe_onehot", int'(st_r) + int'(st_w) + int'(st_rd), 1);
                    check("strobe_vs_m_busy", m_busy, 0);
                    last_strobe_cyc = cyc;
                    if (st_r) tot_rst++;
                    if (st_rd) tot_rd++;
                    if (st_w) begin
                        tot_wr++;
                        wbit_hist.push_back(m_write_bit_data);
                        pwbit = m_write_bit_data;
                    end
                end else if (pend && pend_w && busy && !rsp_valid) begin
                    check("wbit_hold", m_write_bit_data, pwbit);
                end
            end
            @(posedge clk);
            #1;
            m_done = 0;
            m_read_bit_data = 1'($urandom);
            m_presence_detected = 1'($urandom);
            if (rst) begin
                pend = 0; rec = 0; m_busy = 0;
            end else if (st_r || st_w || st_rd) begin
                pend = 1; pend_w = st_w; cnt = $urandom_range(1, 4); m_busy = 1;
            end else if (pend) begin
                if (!never_done) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 0;
                        m_done = 1;
                        idx = tot_rd - rd_base - 1;
                        if (idx >= 0 && idx < 8) m_read_bit_data = rd_byte[idx];
                        m_presence_detected = pres_cfg;
                        rec = $urandom_range(0, 2);
                    end
                end
            end else if (rec > 0) begin
                rec--;
            end else begin
                m_busy = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT presents rsp_valid.
    initial begin
        int         mon_rst, mon_wr, mon_rd, dw;
        exp_t       e;
        logic [7:0] got;
        mon_rst = 0; mon_wr = 0; mon_rd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mon_rst = tot_rst; mon_wr = tot_wr; mon_rd = tot_rd;
            end else if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_presence", rsp_presence, e.pres);
                    check("rsp_err", rsp_err, e.err);
                    check("n_reset_strobes", tot_rst - mon_rst, e.nrst);
                    check("n_write_strobes", tot_wr - mon_wr, e.nwr);
                    check("n_read_strobes", tot_rd - mon_rd, e.nrd);
                    dw  = tot_wr - mon_wr;
                    got = 8'h00;
                    for (int i = 0; i < 8; i++)
                        if (i < dw) got[i] = wbit_hist[mon_wr + i];
                    check("write_bit_sequence", got, e.wseq);
                    check("crc_value", crc_value, e.crc);
                    if (e.chk_to) check("timeout_latency", cyc - last_strobe_cyc, TO + 1);
                    if (e.chk_rsv) check("reserved_latency", cyc - e.acc_cyc, 0);
                    mon_rst = tot_rst; mon_wr = tot_wr; mon_rd = tot_rd;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] data, input bit wait_done);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", cmd_ready, 1);
            return;
        end
        rd_base = tot_rd;
        e = '{data: 8'h00, pres: 1'b0, err: 1'b0, nrst: 0, nwr: 0, nrd: 0, wseq: 8'h00,
              crc: 8'h00, acc_cyc: 0, chk_to: 1'b0, chk_rsv: 1'b0};
        case (op)
            2'd0: begin e.pres = pres_cfg; e.nrst = 1; model_crc = 8'h00; end
            2'd1: begin
                if (never_done) begin
                    e.err = 1'b1; e.nwr = 1; e.wseq = {7'b0, data[0]};
                end else begin
                    e.nwr = 8; e.wseq = data; model_crc = crc_byte(model_crc, data);
                end
            end
            2'd2: begin e.data = rd_byte; e.nrd = 8; model_crc = crc_byte(model_crc, rd_byte); end
            default: begin e.err = 1'b1; e.chk_rsv = 1'b1; end
        endcase
        e.chk_to = never_done;
        e.crc    = CRC_EN ? model_crc : 8'h00;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = 8'($urandom);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        check("ready_low_after_accept", cmd_ready, 0);
        check("busy_after_accept", busy, 1);
        if (wait_done) wait_rsp();
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_wait_expired", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        rst = 1; cmd_valid = 0; cmd_op = 0; cmd_data = 0; crc_clear = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_strobes", {m_start_reset, m_start_write_bit, m_start_read_bit, m_write_bit_data}, 0);
        check("reset_rsp_fields", {rsp_data, rsp_presence, rsp_err}, 0);
        check("reset_crc", crc_value, 0);
        rst = 0;

        pres_cfg = 1'b1; issue(2'd0, 8'h00, 1);
        pres_cfg = 1'b0; issue(2'd0, 8'h00, 1);
        issue(2'd1, 8'hA5, 1);
        rd_byte = 8'h3C; issue(2'd2, 8'h00, 1);
        issue(2'd3, 8'hFF, 1);

        for (int k = 0; k < 40; k++) begin
            pres_cfg = 1'($urandom);
            rd_byte  = 8'($urandom);
            issue(2'($urandom_range(0, 3)), 8'($urandom), 1);
        end

        // Watchdog: master never completes, then a late m_done lands in IDLE.
        never_done = 1'b1;
        issue(2'd1, 8'($urandom), 1);
        never_done = 1'b0;
        repeat (10) @(negedge clk);
        check("late_done_ready", cmd_ready, 1);
        check("late_done_busy", busy, 0);

        // Reset in the middle of a read byte, at the bit-3 strobe.
        rd_byte = 8'($urandom);
        issue(2'd2, 8'h00, 0);
        n = 0;
        while (!(m_start_read_bit && (tot_rd - rd_base) == 4) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_bit3_reached", tot_rd - rd_base, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_strobes", {m_start_reset, m_start_write_bit, m_start_read_bit}, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_crc = 8'h00;
        repeat (20) @(negedge clk);
        check("abort_idle", {cmd_ready, busy}, 2'b10);

`ifdef ONE_WIRE_CRC8_EN
        issue(2'd1, 8'h5A, 1);
        @(negedge clk);
        crc_clear = 1'b1;
        @(negedge clk);
        crc_clear = 1'b0;
        model_crc = 8'h00;
        check("crc_after_clear", crc_value, 0);
        issue(2'd1, 8'h02, 1);
        issue(2'd1, 8'h1C, 1);
        issue(2'd1, 8'hB8, 1);
        issue(2'd1, 8'h01, 1);
        issue(2'd1, 8'h00, 1);
        issue(2'd1, 8'h00, 1);
        issue(2'd1, 8'h00, 1);
        check("crc_rom_body", crc_value, 8'hA2);
        rd_byte = 8'hA2;
        issue(2'd2, 8'h00, 1);
        check("crc_rom_residue", crc_value, 8'h00);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
